// File: rtl/sonar_pkg.sv
// sonar_pkg
//   Shared definitions for the sonar scanner control unit and the datapath
//   debug decoders: the 4-bit state encoding and the default watchdog limit.
package sonar_pkg;

  // State codes are visible on db_estado, so the numeric values are fixed.
  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    PREPARA        = 4'd1,
    ESPERA         = 4'd2,
    MEDE           = 4'd3,
    AGUARDA_MEDIDA = 4'd4,
    TRANSMITE      = 4'd5,
    AGUARDA_TX     = 4'd6,
    PROXIMO_CHAR   = 4'd7,
    FIM_POSICAO    = 4'd8
  } estado_t;

  // 50 ms at 50 MHz.
  localparam int TIMEOUT_DEFAULT = 2_500_000;

endpackage

// File: rtl/contador_m.sv
// contador_m
//   Modulo-M up counter with asynchronous and synchronous clears.
//   Ports:
//     clock   in  rising-edge clock
//     zera_as in  asynchronous clear, active high
//     zera_s  in  synchronous clear (wins over conta)
//     conta   in  count enable; wraps M-1 -> 0
//     fim     out high while the count equals M-1
module contador_m #(
  parameter int M = 16,
  parameter int N = 4
) (
  input  logic clock,
  input  logic zera_as,
  input  logic zera_s,
  input  logic conta,
  output logic fim
);

  logic [N-1:0] r_q;

  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as) begin
      r_q <= '0;
    end else if (zera_s) begin
      r_q <= '0;
    end else if (conta) begin
      if (r_q == N'(M - 1)) r_q <= '0;
      else                  r_q <= r_q + N'(1);
    end
  end

  assign fim = (r_q == N'(M - 1));

endmodule

// File: rtl/sonar_uc.sv
// sonar_uc
//   Control unit for the sonar scanner. Per servo position: wait the
//   inter-measurement interval, trigger one measurement, send the 8-char
//   frame one character at a time, then step the servo. A watchdog aborts a
//   measurement whose echo never returns.
//   Ports:
//     clock, reset            clock and async active-high reset
//     ligar                   level, enables the scan loop
//     fim_distancia           measurement done pulse
//     fim_transmissao         character sent pulse
//     fim_contador_serial     character counter at 7 (level)
//     fim_contador_intervalo  interval counter at M-1 (level)
//     zera .. pronto          Moore-decoded datapath controls
//     db_timeout              last measurement aborted by the watchdog
//     db_estado               current state code
module sonar_uc
  import sonar_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int TW      = $clog2(TIMEOUT)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       fim_distancia,
  input  logic       fim_transmissao,
  input  logic       fim_contador_serial,
  input  logic       fim_contador_intervalo,
  output logic       zera,
  output logic       zera_pwm,
  output logic       reset_updown,
  output logic       conta_intervalo,
  output logic       medir,
  output logic       transmitir,
  output logic       conta_serial,
  output logic       conta_updown,
  output logic       pronto,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  estado_t r_state;
  estado_t w_next;
  logic    r_db_timeout;

  logic    w_wd_clr;
  logic    w_wd_en;
  logic    w_wd_fim;
  logic    w_timeout;

  // Watchdog: cleared in MEDE, counts only while waiting for the echo, so
  // its count is 0 on the first AGUARDA_MEDIDA cycle and fim fires on the
  // TIMEOUT-th cycle of that state.
  assign w_wd_clr = (r_state == MEDE);
  assign w_wd_en  = (r_state == AGUARDA_MEDIDA);

  contador_m #(
    .M (TIMEOUT),
    .N (TW)
  ) u_watchdog (
    .clock   (clock),
    .zera_as (reset),
    .zera_s  (w_wd_clr),
    .conta   (w_wd_en),
    .fim     (w_wd_fim)
  );

  // A real measurement arriving in the expiry cycle takes precedence.
  assign w_timeout = w_wd_en & w_wd_fim & ~fim_distancia;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= INICIAL;
    else       r_state <= w_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 r_db_timeout <= 1'b0;
    else if (r_state == MEDE)  r_db_timeout <= 1'b0;
    else if (w_timeout)        r_db_timeout <= 1'b1;
  end

  // Next-state decode. ligar is only consulted in INICIAL and FIM_POSICAO so
  // a frame in progress always completes.
  always_comb begin
    w_next = r_state;
    case (r_state)
      INICIAL:        if (ligar) w_next = PREPARA;
      PREPARA:        w_next = ESPERA;
      ESPERA:         if (fim_contador_intervalo) w_next = MEDE;
      MEDE:           w_next = AGUARDA_MEDIDA;
      AGUARDA_MEDIDA: if (fim_distancia || w_wd_fim) w_next = TRANSMITE;
      TRANSMITE:      w_next = AGUARDA_TX;
      AGUARDA_TX: begin
        if (fim_transmissao) begin
          if (fim_contador_serial) w_next = FIM_POSICAO;
          else                     w_next = PROXIMO_CHAR;
        end
      end
      PROXIMO_CHAR:   w_next = TRANSMITE;
      FIM_POSICAO:    w_next = ligar ? ESPERA : INICIAL;
      default:        w_next = INICIAL;
    endcase
  end

  // Moore output decode.
  always_comb begin
    zera            = 1'b0;
    zera_pwm        = 1'b0;
    reset_updown    = 1'b0;
    conta_intervalo = 1'b0;
    medir           = 1'b0;
    transmitir      = 1'b0;
    conta_serial    = 1'b0;
    conta_updown    = 1'b0;
    pronto          = 1'b0;
    case (r_state)
      INICIAL:      zera_pwm = 1'b1;
      PREPARA: begin
        zera         = 1'b1;
        reset_updown = 1'b1;
      end
      ESPERA:       conta_intervalo = 1'b1;
      MEDE:         medir = 1'b1;
      TRANSMITE:    transmitir = 1'b1;
      PROXIMO_CHAR: conta_serial = 1'b1;
      FIM_POSICAO: begin
        conta_updown = 1'b1;
        conta_serial = 1'b1;  // wraps the character counter 7 -> 0
        pronto       = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_timeout = r_db_timeout;
  assign db_estado  = r_state;

endmodule

// File: tb/tb_sonar_uc.sv
module tb_sonar_uc;

  logic       clock = 1'b0;
  logic       reset, ligar, fim_distancia, fim_transmissao;
  logic       fim_contador_serial, fim_contador_intervalo;
  logic       zera, zera_pwm, reset_updown, conta_intervalo, medir, transmitir;
  logic       conta_serial, conta_updown, pronto, db_timeout;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;

  // Ideal character counter of the datapath.
  logic [2:0] cnt = 3'd0;
  always @(negedge clock) begin
    if (zera)              cnt <= 3'd0;
    else if (conta_serial) cnt <= cnt + 3'd1;
  end
  assign fim_contador_serial = (cnt == 3'd7);

  // {zera,zera_pwm,reset_updown,conta_intervalo,medir,transmitir,
  //  conta_serial,conta_updown,pronto,db_timeout}
  wire [9:0] outs = {zera, zera_pwm, reset_updown, conta_intervalo, medir,
                     transmitir, conta_serial, conta_updown, pronto, db_timeout};

  sonar_uc #(.TIMEOUT(20)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .ligar                  (ligar),
    .fim_distancia          (fim_distancia),
    .fim_transmissao        (fim_transmissao),
    .fim_contador_serial    (fim_contador_serial),
    .fim_contador_intervalo (fim_contador_intervalo),
    .zera                   (zera),
    .zera_pwm               (zera_pwm),
    .reset_updown           (reset_updown),
    .conta_intervalo        (conta_intervalo),
    .medir                  (medir),
    .transmitir             (transmitir),
    .conta_serial           (conta_serial),
    .conta_updown           (conta_updown),
    .pronto                 (pronto),
    .db_timeout             (db_timeout),
    .db_estado              (db_estado)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // From a sampled TRANSMITE state, answer every character after 2 cycles in
  // AGUARDA_TX until pronto is seen. ligar is dropped once n_tx reaches drop_at.
  task automatic run_frame(input int drop_at, output int n_tx, output int n_prox,
                           output int n_pronto, output int n_updown, output bit done);
    int wait6;
    n_tx = 0; n_prox = 0; n_pronto = 0; n_updown = 0; done = 0; wait6 = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (transmitir)       n_tx++;
      if (db_estado == 4'd7) n_prox++;
      if (conta_updown)     n_updown++;
      if (pronto) begin n_pronto++; done = 1; end
      if (n_tx == drop_at) ligar = 1'b0;
      fim_transmissao = 1'b0;
      if (db_estado == 4'd6) begin
        wait6++;
        if (wait6 == 2) begin fim_transmissao = 1'b1; wait6 = 0; end
      end
      if (!done) tick;
    end
    fim_transmissao = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; ligar = 1'b0; fim_distancia = 1'b0; fim_transmissao = 1'b0;
    fim_contador_intervalo = 1'b0;
    tick; tick;
    checks++;
    if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", db_estado); end
    checks++;
    if (outs !== 10'b0100000000) begin errors++; $display("FAIL reset_outs: got %b expected 0100000000", outs); end
    reset = 1'b0;
    tick;
    checks++;
    if (db_estado !== 4'd0) begin errors++; $display("FAIL idle_no_ligar: got %0d expected 0", db_estado); end
  endtask

  task automatic test_start;
    ligar = 1'b1;
    tick;
    checks++;
    if (db_estado !== 4'd1 || outs !== 10'b1010000000) begin
      errors++; $display("FAIL start_prepara: state %0d outs %b expected 1 1010000000", db_estado, outs);
    end
    tick;
    checks++;
    if (db_estado !== 4'd2 || outs !== 10'b0001000000) begin
      errors++; $display("FAIL start_espera: state %0d outs %b expected 2 0001000000", db_estado, outs);
    end
  endtask

  task automatic test_full_position;
    int tx, px, pr, up; bit dn;
    // Stray pulses outside their wait states do nothing.
    fim_distancia = 1'b1; fim_transmissao = 1'b1;
    tick;
    fim_distancia = 1'b0; fim_transmissao = 1'b0;
    checks++;
    if (db_estado !== 4'd2) begin errors++; $display("FAIL stray_pulses: got %0d expected 2", db_estado); end
    fim_contador_intervalo = 1'b1;
    tick;
    fim_contador_intervalo = 1'b0;
    checks++;
    if (db_estado !== 4'd3 || outs !== 10'b0000100000) begin
      errors++; $display("FAIL mede: state %0d outs %b expected 3 0000100000", db_estado, outs);
    end
    tick;
    checks++;
    if (db_estado !== 4'd4 || medir !== 1'b0) begin
      errors++; $display("FAIL aguarda_medida: state %0d medir %b expected 4 0", db_estado, medir);
    end
    tick; tick;
    fim_distancia = 1'b1;
    tick;
    fim_distancia = 1'b0;
    checks++;
    if (db_estado !== 4'd5 || transmitir !== 1'b1) begin
      errors++; $display("FAIL dist_to_tx: state %0d transmitir %b expected 5 1", db_estado, transmitir);
    end
    run_frame(-1, tx, px, pr, up, dn);
    checks++;
    if (!dn || tx != 8 || px != 7 || pr != 1 || up != 1) begin
      errors++; $display("FAIL frame_counts: done %0d tx %0d prox %0d pronto %0d updown %0d expected 1 8 7 1 1", dn, tx, px, pr, up);
    end
    tick;
    checks++;
    if (db_estado !== 4'd2 || pronto !== 1'b0 || cnt !== 3'd0) begin
      errors++; $display("FAIL after_position: state %0d pronto %b cnt %0d expected 2 0 0", db_estado, pronto, cnt);
    end
  endtask

  task automatic test_timeout;
    int n4, tx, px, pr, up; bit dn;
    fim_contador_intervalo = 1'b1;
    tick;
    fim_contador_intervalo = 1'b0;
    tick;
    n4 = 0;
    while (db_estado == 4'd4 && n4 < 100) begin n4++; tick; end
    checks++;
    if (n4 != 20 || db_estado !== 4'd5 || db_timeout !== 1'b1) begin
      errors++; $display("FAIL watchdog: cycles %0d state %0d timeout %b expected 20 5 1", n4, db_estado, db_timeout);
    end
    run_frame(-1, tx, px, pr, up, dn);
    checks++;
    if (!dn || tx != 8 || db_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_frame: done %0d tx %0d timeout %b expected 1 8 1", dn, tx, db_timeout);
    end
    tick;
    fim_contador_intervalo = 1'b1;
    tick;
    fim_contador_intervalo = 1'b0;
    checks++;
    if (db_estado !== 4'd3 || db_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_hold: state %0d timeout %b expected 3 1", db_estado, db_timeout);
    end
    tick;
    checks++;
    if (db_estado !== 4'd4 || db_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_clear: state %0d timeout %b expected 4 0", db_estado, db_timeout);
    end
  endtask

  // Continues from the first AGUARDA_MEDIDA cycle left by test_timeout.
  task automatic test_simultaneous;
    int tx, px, pr, up; bit dn;
    repeat (19) tick;
    checks++;
    if (db_estado !== 4'd4) begin errors++; $display("FAIL sim_still_waiting: got %0d expected 4", db_estado); end
    fim_distancia = 1'b1;
    tick;
    fim_distancia = 1'b0;
    checks++;
    if (db_estado !== 4'd5 || db_timeout !== 1'b0) begin
      errors++; $display("FAIL sim_priority: state %0d timeout %b expected 5 0", db_estado, db_timeout);
    end
    run_frame(-1, tx, px, pr, up, dn);
    tick;
    checks++;
    if (!dn || db_estado !== 4'd2 || db_timeout !== 1'b0) begin
      errors++; $display("FAIL sim_after: done %0d state %0d timeout %b expected 1 2 0", dn, db_estado, db_timeout);
    end
  endtask

  task automatic test_ligar_drop;
    int tx, px, pr, up; bit dn;
    fim_contador_intervalo = 1'b1;
    tick;
    fim_contador_intervalo = 1'b0;
    tick;
    fim_distancia = 1'b1;
    tick;
    fim_distancia = 1'b0;
    run_frame(3, tx, px, pr, up, dn);
    checks++;
    if (!dn || tx != 8 || px != 7 || pr != 1) begin
      errors++; $display("FAIL drop_frame: done %0d tx %0d prox %0d pronto %0d expected 1 8 7 1", dn, tx, px, pr);
    end
    tick;
    checks++;
    if (db_estado !== 4'd0 || outs !== 10'b0100000000) begin
      errors++; $display("FAIL drop_idle: state %0d outs %b expected 0 0100000000", db_estado, outs);
    end
    tick; tick;
    checks++;
    if (db_estado !== 4'd0) begin errors++; $display("FAIL drop_stays: got %0d expected 0", db_estado); end
  endtask

  task automatic test_reset_mid;
    int n;
    ligar = 1'b1;
    tick; tick;
    fim_contador_intervalo = 1'b1;
    tick;
    fim_contador_intervalo = 1'b0;
    tick;
    n = 0;
    while (db_estado != 4'd5 && n < 100) begin n++; tick; end
    tick;
    checks++;
    if (db_estado !== 4'd6 || db_timeout !== 1'b1) begin
      errors++; $display("FAIL pre_reset: state %0d timeout %b expected 6 1", db_estado, db_timeout);
    end
    reset = 1'b1;
    #2;
    checks++;
    if (db_estado !== 4'd0 || outs !== 10'b0100000000) begin
      errors++; $display("FAIL async_reset: state %0d outs %b expected 0 0100000000", db_estado, outs);
    end
    ligar = 1'b0;
    tick;
    reset = 1'b0;
    fim_transmissao = 1'b1;
    tick;
    fim_transmissao = 1'b0;
    tick;
    checks++;
    if (db_estado !== 4'd0 || outs !== 10'b0100000000) begin
      errors++; $display("FAIL stray_after_reset: state %0d outs %b expected 0 0100000000", db_estado, outs);
    end
  endtask

  initial begin
    test_reset;
    test_start;
    test_full_position;
    test_timeout;
    test_simultaneous;
    test_ligar_drop;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
